// File: rtl/gsim_b_loader_if.sv
// Host b-word stream and solver-side burst signals for the GSIM b-vector loader.
// The master modport is the host/solver side and the slave modport is the loader.
interface gsim_b_loader_if #(
    parameter int DW = 16
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          gs_out_valid;
    logic          in_en;
    logic [DW-1:0] b_in;

    modport master (
        output s_valid, s_data, gs_out_valid,
        input  s_ready, in_en, b_in
    );

    modport slave (
        input  s_valid, s_data, gs_out_valid,
        output s_ready, in_en, b_in
    );
endinterface

// File: rtl/gsim_b_loader.sv
// Buffers one N-word b-vector from the host and replays it to the GSIM solver as an
// N-cycle burst, then waits out the solver result window before the next burst.
module gsim_b_loader #(
    parameter int N       = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    gsim_b_loader_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        solve_cnt,
    output logic              err_timeout
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL    = CW'(N);
    localparam logic [CW-1:0] LAST_WR = CW'(N - 1);
    localparam logic [AW-1:0] LAST_RD = AW'(N - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, BURST, BUSY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_idx;
    logic [WW-1:0] wd;
    logic          seen_hi;
    logic [DW-1:0] vec [N];
    logic          accept, fill_done, complete, timeout_hit, burst_last;

    // Everything facing the solver comes from registers so host activity cannot glitch it.
    assign bus.s_ready = (state != BURST) && (count < FULL);
    assign bus.in_en   = (state == BURST);
    assign bus.b_in    = (state == BURST) ? vec[rd_idx] : '0;
    assign busy        = (state != FILL);

    assign accept     = bus.s_valid && bus.s_ready;
    assign fill_done  = (count == FULL) || (accept && (count == LAST_WR));
    assign burst_last = (state == BURST) && (rd_idx == LAST_RD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            FILL:  if (fill_done) state_next = BURST;
            BURST: if (rd_idx == LAST_RD) state_next = BUSY;
            BUSY: begin
                // A genuine completion wins over a watchdog expiry landing on the same edge.
                if (seen_hi && !bus.gs_out_valid)          complete    = 1'b1;
                else if ((TIMEOUT > 0) && (wd == WD_LAST)) timeout_hit = 1'b1;
                if (complete || timeout_hit) state_next = fill_done ? BURST : FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            rd_idx      <= '0;
            wd          <= '0;
            seen_hi     <= 1'b0;
            done        <= 1'b0;
            solve_cnt   <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            done <= complete;
            if (complete)    solve_cnt   <= solve_cnt + 8'd1;
            if (timeout_hit) err_timeout <= 1'b1;

            if (burst_last) begin
                count  <= '0;
                rd_idx <= '0;
            end else begin
                if (accept)           count  <= count + CW'(1);
                if (state == BURST)   rd_idx <= rd_idx + AW'(1);
            end

            if ((state == BUSY) && (state_next == BUSY)) begin
                wd      <= wd + WW'(1);
                seen_hi <= seen_hi | bus.gs_out_valid;
            end else begin
                wd      <= '0;
                seen_hi <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) vec[count[AW-1:0]] <= bus.s_data;
    end
endmodule

// File: tb/tb_gsim_b_loader.sv
// Directed self-checking bench for gsim_b_loader (N=16, DW=16, TIMEOUT=32).
module tb_gsim_b_loader;
    logic       clk;
    logic       reset;
    logic       busy, done, err_timeout;
    logic [7:0] solve_cnt;
    int         total = 0;
    int         bad   = 0;
    int         exp_cnt = 0;

    gsim_b_loader_if #(.DW(16)) bus ();

    gsim_b_loader #(.N(16), .DW(16), .TIMEOUT(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .solve_cnt   (solve_cnt),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] run did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic run_window(input int hi);
        bus.gs_out_valid = 1'b1;
        repeat (hi) tick();
        bus.gs_out_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.gs_out_valid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
        total++; if (bus.in_en !== 1'b0) begin bad++; $display("FAIL rst_in_en got=%b exp=0", bus.in_en); end
        total++; if (bus.b_in !== 16'h0) begin bad++; $display("FAIL rst_b_in got=%h exp=0000", bus.b_in); end
        total++; if ({busy, done, err_timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, err_timeout}); end
        total++; if (solve_cnt !== 8'd0) begin bad++; $display("FAIL rst_solve_cnt got=%0d exp=0", solve_cnt); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream;
        for (int i = 0; i < 16; i++) begin
            total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL t1_s_ready i=%0d got=%b exp=1", i, bus.s_ready); end
            total++; if (bus.in_en !== 1'b0) begin bad++; $display("FAIL t1_early_in_en i=%0d got=%b exp=0", i, bus.in_en); end
            push(16'(i + 1));
        end
        for (int k = 0; k < 16; k++) begin
            total++; if (bus.in_en !== 1'b1) begin bad++; $display("FAIL t1_in_en k=%0d got=%b exp=1", k, bus.in_en); end
            total++; if (bus.b_in !== 16'(k + 1)) begin bad++; $display("FAIL t1_b_in k=%0d got=%h exp=%h", k, bus.b_in, 16'(k + 1)); end
            total++; if ({busy, bus.s_ready} !== 2'b10) begin bad++; $display("FAIL t1_busy_ready k=%0d got=%b exp=10", k, {busy, bus.s_ready}); end
            tick();
        end
        total++; if ({bus.in_en, busy} !== 2'b01) begin bad++; $display("FAIL t1_after_burst got=%b exp=01", {bus.in_en, busy}); end
        run_window(3);
        exp_cnt++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t1_done got=%b exp=1", done); end
        total++; if (solve_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL t1_solve_cnt got=%0d exp=%0d", solve_cnt, exp_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_end got=%b exp=0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 16; i++) begin
            int gaps = int'($urandom_range(0, 3));
            repeat (gaps) begin
                total++; if (bus.in_en !== 1'b0) begin bad++; $display("FAIL t2_early_in_en i=%0d got=%b exp=0", i, bus.in_en); end
                tick();
            end
            total++; if (bus.in_en !== 1'b0) begin bad++; $display("FAIL t2_early_in_en i=%0d got=%b exp=0", i, bus.in_en); end
            push(16'hA000 + 16'(i));
        end
        for (int k = 0; k < 16; k++) begin
            total++; if ({bus.in_en, bus.b_in} !== {1'b1, 16'hA000 + 16'(k)}) begin bad++; $display("FAIL t2_burst k=%0d got=%b/%h exp=1/%h", k, bus.in_en, bus.b_in, 16'hA000 + 16'(k)); end
            tick();
        end
        run_window(2);
        exp_cnt++;
        total++; if ({done, solve_cnt} !== {1'b1, 8'(exp_cnt)}) begin bad++; $display("FAIL t2_done got=%b/%0d exp=1/%0d", done, solve_cnt, exp_cnt); end
    endtask

    task automatic test_fill_during_busy;
        for (int i = 0; i < 16; i++) push(16'hB000 + 16'(i));
        repeat (16) tick();
        for (int b = 0; b < 17; b++) begin
            bus.gs_out_valid = 1'b1;
            if (b < 16) begin
                total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL t3_s_ready b=%0d got=%b exp=1", b, bus.s_ready); end
                bus.s_valid = 1'b1;
                bus.s_data  = 16'hC000 + 16'(b);
            end else begin
                bus.s_valid = 1'b0;
                total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL t3_s_ready_full got=%b exp=0", bus.s_ready); end
            end
            total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL t3_busy_wait b=%0d got=%b exp=10", b, {busy, done}); end
            tick();
        end
        bus.gs_out_valid = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        exp_cnt++;
        total++; if ({done, solve_cnt} !== {1'b1, 8'(exp_cnt)}) begin bad++; $display("FAIL t3_done got=%b/%0d exp=1/%0d", done, solve_cnt, exp_cnt); end
        for (int k = 0; k < 16; k++) begin
            total++; if ({bus.in_en, bus.b_in} !== {1'b1, 16'hC000 + 16'(k)}) begin bad++; $display("FAIL t3_burst k=%0d got=%b/%h exp=1/%h", k, bus.in_en, bus.b_in, 16'hC000 + 16'(k)); end
            if (k == 1) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL t3_done_pulse got=%b exp=0", done); end
            end
            tick();
        end
    endtask

    task automatic test_same_cycle;
        for (int b = 0; b < 15; b++) begin
            bus.gs_out_valid = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_data  = 16'hE000 + 16'(b);
            tick();
        end
        bus.gs_out_valid = 1'b0;
        bus.s_data = 16'hE00F;
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL t4_s_ready got=%b exp=1", bus.s_ready); end
        tick();
        bus.s_valid = 1'b0;
        exp_cnt++;
        total++; if ({done, solve_cnt} !== {1'b1, 8'(exp_cnt)}) begin bad++; $display("FAIL t4_done got=%b/%0d exp=1/%0d", done, solve_cnt, exp_cnt); end
        for (int k = 0; k < 16; k++) begin
            total++; if ({bus.in_en, bus.b_in} !== {1'b1, 16'hE000 + 16'(k)}) begin bad++; $display("FAIL t4_burst k=%0d got=%b/%h exp=1/%h", k, bus.in_en, bus.b_in, 16'hE000 + 16'(k)); end
            tick();
        end
        total++; if ({bus.in_en, busy, done} !== 3'b010) begin bad++; $display("FAIL t4_after got=%b exp=010", {bus.in_en, busy, done}); end
        total++; if (solve_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL t4_single_inc got=%0d exp=%0d", solve_cnt, exp_cnt); end
    endtask

    task automatic test_timeout;
        repeat (31) tick();
        total++; if ({err_timeout, busy} !== 2'b01) begin bad++; $display("FAIL t5_pre got=%b exp=01", {err_timeout, busy}); end
        tick();
        total++; if ({err_timeout, busy, done} !== 3'b100) begin bad++; $display("FAIL t5_expire got=%b exp=100", {err_timeout, busy, done}); end
        total++; if (solve_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL t5_no_inc got=%0d exp=%0d", solve_cnt, exp_cnt); end
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL t5_s_ready got=%b exp=1", bus.s_ready); end
        for (int i = 0; i < 16; i++) push(16'h5000 + 16'(i));
        repeat (16) tick();
        run_window(2);
        exp_cnt++;
        total++; if ({done, err_timeout, solve_cnt} !== {2'b11, 8'(exp_cnt)}) begin bad++; $display("FAIL t5_sticky got=%b%b/%0d exp=11/%0d", done, err_timeout, solve_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_burst;
        tick();
        for (int i = 0; i < 16; i++) push(16'hF000 + 16'(i));
        repeat (7) tick();
        total++; if ({bus.in_en, bus.b_in} !== {1'b1, 16'hF007}) begin bad++; $display("FAIL t6_burst7 got=%b/%h exp=1/f007", bus.in_en, bus.b_in); end
        #2 reset = 1'b1;
        #1;
        exp_cnt = 0;
        total++; if ({bus.in_en, bus.s_ready, busy, err_timeout} !== 4'b0100) begin bad++; $display("FAIL t6_async got=%b exp=0100", {bus.in_en, bus.s_ready, busy, err_timeout}); end
        total++; if (solve_cnt !== 8'd0) begin bad++; $display("FAIL t6_solve_cnt got=%0d exp=0", solve_cnt); end
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) push(16'h1100 + 16'(i));
        for (int k = 0; k < 16; k++) begin
            total++; if ({bus.in_en, bus.b_in} !== {1'b1, 16'h1100 + 16'(k)}) begin bad++; $display("FAIL t6_burst k=%0d got=%b/%h exp=1/%h", k, bus.in_en, bus.b_in, 16'h1100 + 16'(k)); end
            tick();
        end
        total++; if ({bus.in_en, busy} !== 2'b01) begin bad++; $display("FAIL t6_after got=%b exp=01", {bus.in_en, busy}); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_fill_during_busy();
        test_same_cycle();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
